// File: rtl/rx_pkt_deframer.sv
// Per-channel receive deframer: ADDR_H, ADDR_L, 3-byte -> 2-word payload unpack, XOR checksum.
// S_IDLE wait PktStart | S_ADDR_L addr low byte | S_PAY0..2 payload phase | S_CHK checksum | S_DROP discard
module rx_pkt_deframer #(
  parameter int unsigned PAYLOAD_WORDS = 80,
  parameter logic [15:0] MAX_ADD       = 16'h9600,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic        Cclk,
  input  logic        rstn,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  input  logic        PktStart,
  output logic [15:0] RxAdd,
  output logic        RxAddValid,
  output logic [11:0] RxData,
  output logic        RxValid,
  output logic        PktDone,
  output logic        PktErr,
  output logic [15:0] PktCount,
  output logic [15:0] ErrCount
);

  localparam int WCW = $clog2(PAYLOAD_WORDS + 1);
  localparam int TCW = $clog2(TIMEOUT);
  localparam logic [WCW-1:0] WORDS_LAST = WCW'(PAYLOAD_WORDS - 1);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(TIMEOUT - 1);
  localparam logic [15:0]    LINE_LEN   = 16'(PAYLOAD_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_L, S_PAY0, S_PAY1, S_PAY2, S_CHK, S_DROP
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     addr_h_q, addr_h_d;
  logic [7:0]     b0_q, b0_d;
  logic [3:0]     b1_q, b1_d;
  logic [7:0]     chk_q, chk_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [15:0]    rx_add_d;
  logic [11:0]    rx_data_d;
  logic           add_valid_d, rx_valid_d, pkt_done_d, pkt_err_d;
  logic           pkt_inc, err_inc;
  logic [15:0]    addr_full;
  logic           addr_bad;

  assign addr_full = {addr_h_q, ByteIn};
  assign addr_bad  = (addr_full >= MAX_ADD) || ((addr_full % LINE_LEN) != 16'd0);

  always_comb begin
    state_d     = state_q;
    addr_h_d    = addr_h_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    chk_d       = chk_q;
    wcnt_d      = wcnt_q;
    tmo_d       = tmo_q;
    rx_add_d    = RxAdd;
    rx_data_d   = RxData;
    add_valid_d = 1'b0;
    rx_valid_d  = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_err_d   = 1'b0;
    pkt_inc     = 1'b0;
    err_inc     = 1'b0;

    if (ByteValid) begin
      tmo_d = '0;
      if (PktStart) begin
        // A restart inside a live packet aborts it; from IDLE or DROP it is a clean start.
        if (state_q != S_IDLE && state_q != S_DROP) begin
          pkt_err_d = 1'b1;
          err_inc   = 1'b1;
        end
        addr_h_d = ByteIn;
        chk_d    = ByteIn;
        state_d  = S_ADDR_L;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_ADDR_L: begin
            chk_d = chk_q ^ ByteIn;
            if (addr_bad) begin
              pkt_err_d = 1'b1;
              err_inc   = 1'b1;
              state_d   = S_DROP;
            end else begin
              rx_add_d    = addr_full;
              add_valid_d = 1'b1;
              wcnt_d      = '0;
              state_d     = S_PAY0;
            end
          end
          S_PAY0: begin
            b0_d    = ByteIn;
            chk_d   = chk_q ^ ByteIn;
            state_d = S_PAY1;
          end
          S_PAY1: begin
            b1_d       = ByteIn[3:0];
            chk_d      = chk_q ^ ByteIn;
            rx_data_d  = {b0_q, ByteIn[7:4]};
            rx_valid_d = 1'b1;
            wcnt_d     = wcnt_q + 1'b1;
            state_d    = S_PAY2;
          end
          S_PAY2: begin
            chk_d      = chk_q ^ ByteIn;
            rx_data_d  = {b1_q, ByteIn};
            rx_valid_d = 1'b1;
            wcnt_d     = wcnt_q + 1'b1;
            state_d    = (wcnt_q == WORDS_LAST) ? S_CHK : S_PAY0;
          end
          S_CHK: begin
            pkt_done_d = 1'b1;
            if (ByteIn == chk_q) begin
              pkt_inc = 1'b1;
            end else begin
              pkt_err_d = 1'b1;
              err_inc   = 1'b1;
            end
            state_d = S_IDLE;
          end
          S_DROP: ;
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        state_d = S_IDLE;
        // DROP already charged its error on entry.
        if (state_q != S_DROP) begin
          pkt_err_d = 1'b1;
          err_inc   = 1'b1;
        end
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_h_q   <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      chk_q      <= '0;
      wcnt_q     <= '0;
      tmo_q      <= '0;
      RxAdd      <= '0;
      RxAddValid <= 1'b0;
      RxData     <= '0;
      RxValid    <= 1'b0;
      PktDone    <= 1'b0;
      PktErr     <= 1'b0;
      PktCount   <= '0;
      ErrCount   <= '0;
    end else begin
      state_q    <= state_d;
      addr_h_q   <= addr_h_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      chk_q      <= chk_d;
      wcnt_q     <= wcnt_d;
      tmo_q      <= tmo_d;
      RxAdd      <= rx_add_d;
      RxAddValid <= add_valid_d;
      RxData     <= rx_data_d;
      RxValid    <= rx_valid_d;
      PktDone    <= pkt_done_d;
      PktErr     <= pkt_err_d;
      if (pkt_inc && PktCount != 16'hFFFF) PktCount <= PktCount + 16'd1;
      if (err_inc && ErrCount != 16'hFFFF) ErrCount <= ErrCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_rx_pkt_deframer.sv
// Directed bench for rx_pkt_deframer: expected words/addresses/status pushed on drive, popped on output.
module tb_rx_pkt_deframer;
  localparam int TIMEOUT = 4096;

  logic        Cclk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  ByteIn = 8'h00;
  logic        ByteValid = 1'b0;
  logic        PktStart = 1'b0;
  logic [15:0] RxAdd;
  logic        RxAddValid;
  logic [11:0] RxData;
  logic        RxValid;
  logic        PktDone;
  logic        PktErr;
  logic [15:0] PktCount;
  logic [15:0] ErrCount;

  rx_pkt_deframer #(.PAYLOAD_WORDS(80), .MAX_ADD(16'h9600), .TIMEOUT(TIMEOUT)) dut (
    .Cclk(Cclk), .rstn(rstn), .ByteIn(ByteIn), .ByteValid(ByteValid), .PktStart(PktStart),
    .RxAdd(RxAdd), .RxAddValid(RxAddValid), .RxData(RxData), .RxValid(RxValid),
    .PktDone(PktDone), .PktErr(PktErr), .PktCount(PktCount), .ErrCount(ErrCount)
  );

  always #5 Cclk = ~Cclk;

  int n_tests = 0;
  int n_fail = 0;
  int n_words_seen = 0;
  int exp_pkt = 0;
  int exp_err = 0;

  logic [11:0] exp_words[$];
  logic [15:0] exp_adds[$];
  logic [1:0]  exp_stat[$];   // {PktDone, PktErr}

  logic [11:0] mon_w;
  logic [15:0] mon_a;
  logic [1:0]  mon_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge Cclk) begin
    if (rstn === 1'b1) begin
      if (RxValid === 1'b1) begin
        n_words_seen++;
        check("word_expected", 32'(exp_words.size() > 0), 32'd1);
        if (exp_words.size() > 0) begin
          mon_w = exp_words.pop_front();
          check("rx_data", 32'(RxData), 32'(mon_w));
        end
      end
      if (RxAddValid === 1'b1) begin
        check("add_expected", 32'(exp_adds.size() > 0), 32'd1);
        if (exp_adds.size() > 0) begin
          mon_a = exp_adds.pop_front();
          check("rx_add", 32'(RxAdd), 32'(mon_a));
        end
      end
      if (PktDone === 1'b1 || PktErr === 1'b1) begin
        check("stat_expected", 32'(exp_stat.size() > 0), 32'd1);
        if (exp_stat.size() > 0) begin
          mon_s = exp_stat.pop_front();
          check("done_err", 32'({PktDone, PktErr}), 32'(mon_s));
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic st, input int gap);
    repeat (gap) begin
      @(negedge Cclk);
      ByteValid = 1'b0;
      PktStart  = 1'b0;
    end
    @(negedge Cclk);
    ByteIn    = b;
    ByteValid = 1'b1;
    PktStart  = st;
    @(posedge Cclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Cclk);
      ByteValid = 1'b0;
      PktStart  = 1'b0;
    end
  endtask

  // Sends ADDR_H, ADDR_L, npay bytes of the 12/34/56 pattern and optionally the checksum.
  task automatic packet(input logic [15:0] addr, input bit legal, input int npay,
                        input bit with_chk, input logic [7:0] chk_flip, input int gap,
                        input bit abort_prev);
    logic [7:0] pat [3];
    logic [7:0] x, b, b0, b1;
    pat[0] = 8'h12; pat[1] = 8'h34; pat[2] = 8'h56;
    b0 = 8'h00; b1 = 8'h00;
    if (abort_prev) exp_stat.push_back(2'b01);
    x = addr[15:8];
    send(addr[15:8], 1'b1, gap);
    if (abort_prev) check("abort_err", 32'(PktErr), 32'd1);
    x = x ^ addr[7:0];
    if (!legal) begin
      exp_stat.push_back(2'b01);
      send(addr[7:0], 1'b0, gap);
      check("drop_err", 32'({PktErr, RxAddValid}), 32'b10);
      return;
    end
    exp_adds.push_back(addr);
    send(addr[7:0], 1'b0, gap);
    check("add_latency", 32'({RxAddValid, RxAdd}), 32'({1'b1, addr}));
    for (int i = 0; i < npay; i++) begin
      b = pat[i % 3];
      x = x ^ b;
      if (i % 3 == 0) b0 = b;
      if (i % 3 == 1) begin
        b1 = b;
        exp_words.push_back({b0, b[7:4]});
      end
      if (i % 3 == 2) exp_words.push_back({b1[3:0], b});
      send(b, 1'b0, gap);
      if (i % 3 != 0) check("word_latency", 32'(RxValid), 32'd1);
    end
    if (with_chk) begin
      exp_stat.push_back({1'b1, chk_flip != 8'h00});
      send(x ^ chk_flip, 1'b0, gap);
      check("done_latency", 32'({PktDone, PktErr}), 32'({1'b1, chk_flip != 8'h00}));
    end
  endtask

  task automatic check_drained();
    check("words_pending", 32'(exp_words.size()), 32'd0);
    check("adds_pending", 32'(exp_adds.size()), 32'd0);
    check("stat_pending", 32'(exp_stat.size()), 32'd0);
  endtask

  task automatic check_counts();
    check("pkt_count", 32'(PktCount), 32'(exp_pkt));
    check("err_count", 32'(ErrCount), 32'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int k_hit;

    repeat (3) @(negedge Cclk);
    check("reset_outputs", {RxAdd, RxAddValid, RxData, RxValid, PktDone, PktErr}, 32'd0);
    check("reset_counts", {PktCount, ErrCount}, 32'd0);
    @(negedge Cclk);
    rstn = 1'b1;
    idle(2);

    // good packet
    w0 = n_words_seen;
    packet(16'h00A0, 1'b1, 120, 1'b1, 8'h00, 0, 1'b0);
    exp_pkt++;
    idle(3);
    check_drained();
    check("good_word_count", 32'(n_words_seen - w0), 32'd80);
    check_counts();

    // bad checksum: words still delivered
    w0 = n_words_seen;
    packet(16'h00A0, 1'b1, 120, 1'b1, 8'h01, 0, 1'b0);
    exp_err++;
    idle(3);
    check_drained();
    check("badchk_word_count", 32'(n_words_seen - w0), 32'd80);
    check_counts();

    // illegal addresses; DROP timeout must not add a second error
    packet(16'h9600, 1'b0, 0, 1'b0, 8'h00, 0, 1'b0);
    exp_err++;
    idle(TIMEOUT + 100);
    check_drained();
    check_counts();
    packet(16'h0051, 1'b0, 0, 1'b0, 8'h00, 0, 1'b0);
    exp_err++;
    idle(3);
    check_counts();
    w0 = n_words_seen;
    packet(16'h0000, 1'b1, 120, 1'b1, 8'h00, 0, 1'b0);
    exp_pkt++;
    idle(3);
    check_drained();
    check("after_drop_word_count", 32'(n_words_seen - w0), 32'd80);
    check_counts();

    // early restart after 40 payload bytes
    w0 = n_words_seen;
    packet(16'h00A0, 1'b1, 40, 1'b0, 8'h00, 0, 1'b0);
    check("partial_word_count", 32'(n_words_seen - w0), 32'd26);
    packet(16'h0050, 1'b1, 120, 1'b1, 8'h00, 0, 1'b1);
    exp_err++;
    exp_pkt++;
    idle(3);
    check_drained();
    check("restart_word_count", 32'(n_words_seen - w0), 32'd106);
    check_counts();

    // stall mid-payload
    packet(16'h00F0, 1'b1, 10, 1'b0, 8'h00, 0, 1'b0);
    exp_stat.push_back(2'b01);
    k_hit = -1;
    for (int k = 1; k <= TIMEOUT + 200; k++) begin
      @(negedge Cclk);
      ByteValid = 1'b0;
      PktStart  = 1'b0;
      @(posedge Cclk);
      #1;
      if (PktErr === 1'b1) begin
        k_hit = k;
        break;
      end
    end
    exp_err++;
    check("timeout_cycle", 32'(k_hit), 32'(TIMEOUT));
    send(8'h12, 1'b0, 0);
    send(8'h34, 1'b0, 0);
    send(8'h56, 1'b0, 0);
    idle(3);
    check_drained();
    check_counts();

    // gapped input, highest legal line address
    w0 = n_words_seen;
    packet(16'h95B0, 1'b1, 120, 1'b1, 8'h00, 4, 1'b0);
    exp_pkt++;
    idle(3);
    check_drained();
    check("gapped_word_count", 32'(n_words_seen - w0), 32'd80);
    check_counts();

    // reset mid-packet
    packet(16'h01E0, 1'b1, 20, 1'b0, 8'h00, 0, 1'b0);
    idle(2);
    check_drained();
    @(negedge Cclk);
    rstn = 1'b0;
    #1;
    check("midrst_outputs", {RxAdd, RxAddValid, RxData, RxValid, PktDone, PktErr}, 32'd0);
    check("midrst_counts", {PktCount, ErrCount}, 32'd0);
    exp_pkt = 0;
    exp_err = 0;
    @(negedge Cclk);
    rstn = 1'b1;
    idle(2);
    w0 = n_words_seen;
    packet(16'h0000, 1'b1, 120, 1'b1, 8'h00, 0, 1'b0);
    exp_pkt++;
    idle(3);
    check_drained();
    check("post_reset_word_count", 32'(n_words_seen - w0), 32'd80);
    check_counts();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
